// File: rtl/sys_cmd_initiator_pkg.sv
// sys_cmd_initiator_pkg: opcodes, command-type and FSM state encodings shared by the command initiator
package sys_cmd_initiator_pkg;

    localparam logic [7:0] OPC_WR  = 8'hAA;
    localparam logic [7:0] OPC_RD  = 8'hBB;
    localparam logic [7:0] OPC_ALU = 8'hCC;
    localparam logic [7:0] OPC_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR      = 2'd0,
        CMD_RD      = 2'd1,
        CMD_ALU     = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [3:0] {
        IDLE,
        SEND_OPC,
        SEND_ADDR,
        SEND_DATA,
        SEND_OPA,
        SEND_OPB,
        SEND_FUN,
        WAIT_B1,
        WAIT_B2
    } state_e;

    function automatic logic [7:0] opcode(input cmd_type_e t);
        return t == CMD_WR ? OPC_WR : t == CMD_RD ? OPC_RD : t == CMD_ALU ? OPC_ALU : OPC_NOP;
    endfunction

endpackage

// File: rtl/sys_cmd_initiator_rsp_timer.sv
// rsp_timer: response timeout down-counter
//   CLK, RST(async, active-low) | clear: load TIMEOUT_CYCLES | enable: count one idle wait cycle
//   expire: high on the TIMEOUT_CYCLES-th consecutive enabled cycle since the last clear
module rsp_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            cnt <= '0;
        else if (clear)
            cnt <= W'(TIMEOUT_CYCLES);
        else if (enable && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = enable && cnt == W'(1);

endmodule

// File: rtl/sys_cmd_initiator.sv
// sys_cmd_initiator: frames one host command onto UART TX and collects its 0-2 byte response from UART RX
//   CLK, RST(async, active-low)
//   CMD_VLD/CMD_RDY handshake with CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OPB, CMD_FUN (latched on accept)
//   TX_DATA/TX_VLD/TX_RDY byte stream to UART TX; RX_DATA/RX_VLD byte pulses from UART RX
//   RSP_DATA held response word; RSP_VLD completion pulse; RSP_ERR timeout pulse
module sys_cmd_initiator #(
    parameter int DATA_WIDTH     = 8,
    parameter int RF_ADDR        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CMD_VLD,
    output logic                    CMD_RDY,
    input  logic [1:0]              CMD_TYPE,
    input  logic [RF_ADDR-1:0]      CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]   CMD_DATA,
    input  logic [DATA_WIDTH-1:0]   CMD_OPB,
    input  logic [3:0]              CMD_FUN,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VLD,
    input  logic                    TX_RDY,
    input  logic [DATA_WIDTH-1:0]   RX_DATA,
    input  logic                    RX_VLD,
    output logic [2*DATA_WIDTH-1:0] RSP_DATA,
    output logic                    RSP_VLD,
    output logic                    RSP_ERR
);
    import sys_cmd_initiator_pkg::*;

    state_e                state;
    cmd_type_e             typ_q;
    logic [RF_ADDR-1:0]    addr_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [3:0]            fun_q;
    logic [DATA_WIDTH-1:0] b1_q;
    logic                  waiting;
    logic                  last_hs;
    logic                  expire;

    assign CMD_RDY = state == IDLE;
    assign waiting = state == WAIT_B1 || state == WAIT_B2;
    // The final frame byte of a command that expects a response arms the timer.
    assign last_hs = TX_RDY && ((state == SEND_ADDR && typ_q == CMD_RD) || state == SEND_FUN);

    rsp_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (last_hs || (waiting && RX_VLD)),
        .enable (waiting && !RX_VLD),
        .expire (expire)
    );

    // SEND_* states are only entered with TX_VLD set, so TX_RDY alone marks the handshake there.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            typ_q    <= CMD_WR;
            addr_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            b1_q     <= '0;
            TX_DATA  <= '0;
            TX_VLD   <= 1'b0;
            RSP_DATA <= '0;
            RSP_VLD  <= 1'b0;
            RSP_ERR  <= 1'b0;
        end else begin
            RSP_VLD <= 1'b0;
            RSP_ERR <= 1'b0;
            case (state)
                IDLE: if (CMD_VLD) begin
                    typ_q   <= cmd_type_e'(CMD_TYPE);
                    addr_q  <= CMD_ADDR;
                    a_q     <= CMD_DATA;
                    b_q     <= CMD_OPB;
                    fun_q   <= CMD_FUN;
                    state   <= SEND_OPC;
                    TX_VLD  <= 1'b1;
                    TX_DATA <= DATA_WIDTH'(opcode(cmd_type_e'(CMD_TYPE)));
                end
                SEND_OPC: if (TX_RDY) begin
                    state   <= typ_q == CMD_ALU ? SEND_OPA : typ_q == CMD_ALU_NOP ? SEND_FUN : SEND_ADDR;
                    TX_DATA <= typ_q == CMD_ALU ? a_q : typ_q == CMD_ALU_NOP ? DATA_WIDTH'(fun_q) : DATA_WIDTH'(addr_q);
                end
                SEND_ADDR: if (TX_RDY) begin
                    state   <= typ_q == CMD_WR ? SEND_DATA : WAIT_B1;
                    TX_VLD  <= typ_q == CMD_WR;
                    TX_DATA <= typ_q == CMD_WR ? a_q : TX_DATA;
                end
                SEND_DATA: if (TX_RDY) begin
                    state    <= IDLE;
                    TX_VLD   <= 1'b0;
                    RSP_VLD  <= 1'b1;
                    RSP_DATA <= '0;
                end
                SEND_OPA: if (TX_RDY) begin
                    state   <= SEND_OPB;
                    TX_DATA <= b_q;
                end
                SEND_OPB: if (TX_RDY) begin
                    state   <= SEND_FUN;
                    TX_DATA <= DATA_WIDTH'(fun_q);
                end
                SEND_FUN: if (TX_RDY) begin
                    state  <= WAIT_B1;
                    TX_VLD <= 1'b0;
                end
                WAIT_B1: if (RX_VLD) begin
                    if (typ_q == CMD_RD) begin
                        state    <= IDLE;
                        RSP_VLD  <= 1'b1;
                        RSP_DATA <= {{DATA_WIDTH{1'b0}}, RX_DATA};
                    end else begin
                        state <= WAIT_B2;
                        b1_q  <= RX_DATA;
                    end
                end else if (expire) begin
                    state   <= IDLE;
                    RSP_ERR <= 1'b1;
                end
                WAIT_B2: if (RX_VLD) begin
                    state    <= IDLE;
                    RSP_VLD  <= 1'b1;
                    RSP_DATA <= {RX_DATA, b1_q};
                end else if (expire) begin
                    state   <= IDLE;
                    RSP_ERR <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_cmd_initiator.sv
// tb_sys_cmd_initiator: scoreboard bench for the command initiator
module tb_sys_cmd_initiator;

    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } rsp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          CMD_VLD = 1'b0;
    logic          CMD_RDY;
    logic [1:0]    CMD_TYPE = '0;
    logic [3:0]    CMD_ADDR = '0;
    logic [DW-1:0] CMD_DATA = '0;
    logic [DW-1:0] CMD_OPB = '0;
    logic [3:0]    CMD_FUN = '0;
    logic [DW-1:0] TX_DATA;
    logic          TX_VLD;
    logic          TX_RDY = 1'b1;
    logic [DW-1:0] RX_DATA = '0;
    logic          RX_VLD = 1'b0;
    logic [15:0]   RSP_DATA;
    logic          RSP_VLD;
    logic          RSP_ERR;

    int   checks = 0;
    int   errs = 0;
    logic tog = 1'b0;
    logic [7:0] tx_q[$];
    rsp_t rsp_q[$];
    logic [7:0] exp_b;
    rsp_t exp_r;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [7:0] pd = '0;
    int   n;

    sys_cmd_initiator #(.DATA_WIDTH(DW), .RF_ADDR(4), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_TYPE(CMD_TYPE),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN),
        .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_RDY(TX_RDY), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD),
        .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD), .RSP_ERR(RSP_ERR)
    );

    initial forever #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        #1;
        TX_RDY = tog ? ~TX_RDY : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errs=%0d", errs);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            pv <= 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("tx_hold_vld", TX_VLD, 1);
                chk("tx_hold_data", TX_DATA, pd);
            end
            if (TX_VLD && TX_RDY) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL tx_unexpected: got byte %0h, expected none", TX_DATA);
                end else begin
                    exp_b = tx_q.pop_front();
                    chk("tx_byte", TX_DATA, exp_b);
                end
            end
            if (RSP_VLD || RSP_ERR) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL rsp_unexpected: got vld=%0b err=%0b data=%0h, expected none", RSP_VLD, RSP_ERR, RSP_DATA);
                end else begin
                    exp_r = rsp_q.pop_front();
                    chk("rsp_vld", RSP_VLD, !exp_r.err);
                    chk("rsp_err", RSP_ERR, exp_r.err);
                    chk("rsp_data", RSP_DATA, exp_r.data);
                end
            end
            pv <= TX_VLD;
            pr <= TX_RDY;
            pd <= TX_DATA;
        end
    end

    task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d, input logic [7:0] ob, input logic [3:0] f);
        @(posedge CLK);
        #1;
        chk("cmd_rdy_idle", CMD_RDY, 1);
        CMD_TYPE = t;
        CMD_ADDR = a;
        CMD_DATA = d;
        CMD_OPB  = ob;
        CMD_FUN  = f;
        CMD_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        CMD_VLD  = 1'b0;
        CMD_DATA = 8'hFF;
        CMD_OPB  = 8'hFF;
    endtask

    task automatic wait_rsp(output int cnt);
        cnt = 0;
        do begin
            @(negedge CLK);
            cnt++;
        end while (!(RSP_VLD || RSP_ERR) && cnt < 300);
        if (!(RSP_VLD || RSP_ERR)) begin
            checks++;
            errs++;
            $display("FAIL rsp_timeout: got no response pulse, expected one within 300 cycles");
        end
    endtask

    task automatic tx_done();
        int k = 0;
        while ((tx_q.size() != 0 || TX_VLD) && k < 300) begin
            @(negedge CLK);
            k++;
        end
        if (k == 300) begin
            checks++;
            errs++;
            $display("FAIL tx_stall: got %0d bytes pending, expected 0", tx_q.size());
        end
    endtask

    task automatic rx(input logic [7:0] b);
        @(posedge CLK);
        #1;
        RX_DATA = b;
        RX_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_VLD  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_rdy"}, CMD_RDY, 1);
        chk({tag, "_tx_vld"}, TX_VLD, 0);
        chk({tag, "_tx_data"}, TX_DATA, 0);
        chk({tag, "_rsp_data"}, RSP_DATA, 0);
        chk({tag, "_rsp_vld"}, RSP_VLD, 0);
        chk({tag, "_rsp_err"}, RSP_ERR, 0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        RST = 1'b1;

        // write: AA,03,5A back to back, RSP_VLD in cycle 4
        tx_q.push_back(8'hAA); tx_q.push_back(8'h03); tx_q.push_back(8'h5A);
        rsp_q.push_back('{err: 1'b0, data: 16'h0000});
        issue(2'd0, 4'd3, 8'h5A, 8'h00, 4'd0);
        wait_rsp(n);
        chk("write_latency", n, 4);
        chk("write_cmd_rdy", CMD_RDY, 1);

        // read with TX_RDY toggling
        tog = 1'b1;
        tx_q.push_back(8'hBB); tx_q.push_back(8'h02);
        rsp_q.push_back('{err: 1'b0, data: 16'h0077});
        issue(2'd1, 4'd2, 8'h00, 8'h00, 4'd0);
        tx_done();
        tog = 1'b0;
        rx(8'h77);
        wait_rsp(n);

        // ALU op
        tx_q.push_back(8'hCC); tx_q.push_back(8'h0A); tx_q.push_back(8'h03); tx_q.push_back(8'h02);
        rsp_q.push_back('{err: 1'b0, data: 16'h001E});
        issue(2'd2, 4'd0, 8'h0A, 8'h03, 4'd2);
        tx_done();
        rx(8'h1E);
        rx(8'h00);
        wait_rsp(n);

        // no-operand op, no response: timeout after 16 wait cycles, data unchanged
        tx_q.push_back(8'hDD); tx_q.push_back(8'h01);
        rsp_q.push_back('{err: 1'b1, data: 16'h001E});
        issue(2'd3, 4'd0, 8'h00, 8'h00, 4'd1);
        wait_rsp(n);
        chk("timeout_latency", n, 19);
        chk("timeout_no_vld", RSP_VLD, 0);
        chk("timeout_cmd_rdy", CMD_RDY, 1);

        // stray RX during send and CMD_VLD while busy are ignored
        tog = 1'b1;
        tx_q.push_back(8'hCC); tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03);
        rsp_q.push_back('{err: 1'b0, data: 16'h1234});
        issue(2'd2, 4'd0, 8'h01, 8'h02, 4'd3);
        chk("busy_cmd_rdy", CMD_RDY, 0);
        RX_DATA = 8'hEE;
        RX_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_VLD   = 1'b0;
        CMD_TYPE = 2'd0;
        CMD_VLD  = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        CMD_VLD  = 1'b0;
        tx_done();
        tog = 1'b0;
        rx(8'h34);
        rx(8'h12);
        wait_rsp(n);

        // reset while in WAIT_B2 aborts silently
        tx_q.push_back(8'hCC); tx_q.push_back(8'h05); tx_q.push_back(8'h06); tx_q.push_back(8'h00);
        issue(2'd2, 4'd0, 8'h05, 8'h06, 4'd0);
        tx_done();
        rx(8'hAB);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (30) @(negedge CLK);

        // next command after reset runs normally
        tx_q.push_back(8'hBB); tx_q.push_back(8'h05);
        rsp_q.push_back('{err: 1'b0, data: 16'h0099});
        issue(2'd1, 4'd5, 8'h00, 8'h00, 4'd0);
        tx_done();
        rx(8'h99);
        wait_rsp(n);
        repeat (5) @(negedge CLK);

        chk("tx_queue_empty", tx_q.size(), 0);
        chk("rsp_queue_empty", rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
